mul_ctrl: RTL

Sequencing controller for the team's 8-bit shift-add multiplier datapath. It owns the four operand registers RX/RY/RZ/RT and accepts load and multiply commands over a valid/ready handshake. A multiply runs as a WIDTH-cycle iterative shift-add, publishes the 16-bit product with a one-cycle strobe and writes the low byte back to a destination register. It sits between the command source (switch/button front end or test driver) and the result display.

---
 rtl/mul_ctrl_if.sv | 36 +++
 rtl/mul_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: command handshake and result/register-file bus for mul_ctrl.
//   cmd_valid/cmd_ready   valid/ready command handshake
//   cmd_op/dst/src1/src2  command opcode and register selects
//   cmd_imm               load immediate
//   result/result_valid   last product and its one-cycle strobe
//   busy                  multiply in progress (RUN or DONE)
//   rx/ry/rz/rt           register file contents
// master = command source / display side, slave = controller.
interface mul_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_op;
  logic [1:0]           cmd_dst;
  logic [1:0]           cmd_src1;
  logic [1:0]           cmd_src2;
  logic [WIDTH-1:0]     cmd_imm;
  logic [2*WIDTH-1:0]   result;
  logic                 result_valid;
  logic                 busy;
  logic [WIDTH-1:0]     rx;
  logic [WIDTH-1:0]     ry;
  logic [WIDTH-1:0]     rz;
  logic [WIDTH-1:0]     rt;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
    input  cmd_ready, result, result_valid, busy, rx, ry, rz, rt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
    output cmd_ready, result, result_valid, busy, rx, ry, rz, rt
  );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing controller for the 8-bit shift-add multiplier.
// Owns registers RX/RY/RZ/RT, accepts load/multiply commands over a
// valid/ready handshake, runs a WIDTH-cycle shift-add multiply, publishes
// the 2*WIDTH product with a one-cycle strobe and writes the low WIDTH bits
// back to the destination register.
// Ports:
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  mul_ctrl_if slave modport (commands in, result/registers out)
module mul_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  mul_ctrl_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0][WIDTH-1:0]   regs_q, regs_d;
  logic [PW-1:0]           result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic [PW-1:0]           acc_q, acc_d;
  logic [PW-1:0]           mcand_q, mcand_d;
  logic [WIDTH-1:0]        mplier_q, mplier_d;
  logic [CW-1:0]           count_q, count_d;
  logic [1:0]              dst_q, dst_d;

  logic                    busy;
  logic                    accept;
  logic [PW-1:0]           acc_sum;

  // Handshake status decoded straight from state
  assign busy   = (state_q != S_IDLE);
  assign accept = bus.cmd_valid && bus.cmd_ready;

  // Partial product gated by the current multiplier LSB
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      regs_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      count_q        <= '0;
      dst_q          <= '0;
    end else begin
      state_q        <= state_d;
      regs_q         <= regs_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      acc_q          <= acc_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      count_q        <= count_d;
      dst_q          <= dst_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d        = state_q;
    regs_d         = regs_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    count_d        = count_q;
    dst_d          = dst_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.cmd_op == OP_LOAD) begin
            regs_d[bus.cmd_dst] = bus.cmd_imm;
          end else if (bus.cmd_op == OP_MUL) begin
            // Operands captured here, so src/dst aliasing is harmless
            mplier_d = regs_q[bus.cmd_src1];
            mcand_d  = PW'(regs_q[bus.cmd_src2]);
            dst_d    = bus.cmd_dst;
            acc_d    = '0;
            count_d  = '0;
            state_d  = S_RUN;
          end
        end
      end

      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          result_d       = acc_sum;
          regs_d[dst_q]  = acc_sum[WIDTH-1:0];
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready    = !busy && !rst;
  assign bus.busy         = busy;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.rx           = regs_q[0];
  assign bus.ry           = regs_q[1];
  assign bus.rz           = regs_q[2];
  assign bus.rt           = regs_q[3];

endmodule
